mem_bus_arbiter: RTL

- Shares the single memory bus (load/store/type/addr/data/out/stall) between three requesters: 0 = instruction fetch, 1 = data load/store, 2 = debug/monitor port.
- Sits between the CPU stage logic and the memory module, replacing the direct state-based bus muxing.
- Sequences one transaction at a time through an issue/wait/respond FSM, with round-robin fairness and a stall timeout.

---
 rtl/mem_bus_arbiter_pkg.sv | 38 +++
 rtl/mem_bus_arbiter_rr_pick3.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter: FSM state encoding,
// requester indices, the "no owner" marker and the funct3 access-type codes
// carried on mem_type. Also provides a small index-to-one-hot helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] REQ_IF     = 2'd0;
  localparam logic [1:0] REQ_DATA   = 2'd1;
  localparam logic [1:0] REQ_DBG    = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Index 3 (no owner) maps to an all-zero vector so it can never pulse a
  // requester's gnt or done line.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] vec;
    case (idx)
      2'd0:    vec = 3'b001;
      2'd1:    vec = 3'b010;
      2'd2:    vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick3.sv
// rr_pick3
// Combinational round-robin picker for three requesters. The scan starts at
// the requester after the previous winner and wraps around.
// Ports:
//   req   - per-requester request bits
//   last  - index of the previous winner (3 is treated like 2)
//   valid - at least one request is present
//   idx   - index of the chosen requester (meaningful only when valid)
module rr_pick3
  import mem_bus_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  // Each arm lists the requesters in priority order for the given last
  // winner; the final fallback is the previous winner itself.
  always_comb begin
    valid = |req;
    idx   = REQ_IF;
    case (last)
      REQ_IF: begin
        if (req[1])      idx = REQ_DATA;
        else if (req[2]) idx = REQ_DBG;
        else             idx = REQ_IF;
      end
      REQ_DATA: begin
        if (req[2])      idx = REQ_DBG;
        else if (req[0]) idx = REQ_IF;
        else             idx = REQ_DATA;
      end
      default: begin
        if (req[0])      idx = REQ_IF;
        else if (req[1]) idx = REQ_DATA;
        else             idx = REQ_DBG;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory bus between instruction fetch (0), data load/store (1)
// and the debug/monitor port (2). One transaction runs at a time through an
// IDLE -> ISSUE -> WAIT -> RESP sequence, with round-robin arbitration and a
// stall timeout. The winning command is latched in IDLE, so requester inputs
// are ignored for the rest of the transaction.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   req/req_load/req_store   - per-requester request and command bits
//   req_type/addr/wdata      - per-requester packed funct3, address, store data
//   gnt, done                - one-hot accept / completion pulses
//   rdata, err               - result and error flag, valid with done
//   mem_load..mem_data       - bus toward the memory
//   mem_out, mem_stall       - read data and busy indication from the memory
//   busy, owner              - not-idle flag and current owner (3 when idle)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_load,
  input  logic [NREQ-1:0]      req_store,
  input  logic [3*NREQ-1:0]    req_type,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic                 mem_load,
  output logic                 mem_store,
  output logic [2:0]           mem_type,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_data,
  input  logic [31:0]          mem_out,
  input  logic                 mem_stall,
  output logic                 busy,
  output logic [1:0]           owner
);

  arb_state_t state, state_next;

  // rr_last is the previous winner for arbitration and, while busy, also the
  // current owner, since it is updated exactly when a transaction starts.
  logic [1:0]  rr_last;
  logic        cmd_load, cmd_store;
  logic [2:0]  cmd_type;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [TW-1:0] cnt;
  logic [TW:0]   cnt_inc;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic        sel_load, sel_store;
  logic [2:0]  sel_type;
  logic [31:0] sel_addr, sel_wdata;
  logic        cmd_legal;
  logic        timeout_hit;

  rr_pick3 u_pick (
    .req   (req),
    .last  (rr_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign cmd_legal = cmd_load ^ cmd_store;

  // The counter is widened by one bit so the compare cannot wrap when
  // TIMEOUT sits at the top of the TW range.
  assign cnt_inc     = {1'b0, cnt} + {{TW{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == (TW+1)'(TIMEOUT));

  // Pull the winning requester's command out of the packed input buses.
  always_comb begin
    sel_load  = 1'b0;
    sel_store = 1'b0;
    sel_type  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == i[1:0]) begin
        sel_load  = req_load[i];
        sel_store = req_store[i];
        sel_type  = req_type[3*i +: 3];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. An illegal command skips WAIT entirely; a stalled
  // access leaves WAIT either when the memory finishes or on timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = cmd_legal ? WAIT : RESP;
      WAIT:    if (!mem_stall || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch, round-robin pointer, stall counter and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last   <= REQ_DBG;
      cmd_load  <= 1'b0;
      cmd_store <= 1'b0;
      cmd_type  <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            rr_last   <= pick_idx;
            cmd_load  <= sel_load;
            cmd_store <= sel_store;
            cmd_type  <= sel_type;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
          end
        end
        ISSUE: begin
          if (!cmd_legal) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        WAIT: begin
          if (!mem_stall) begin
            rdata_q <= cmd_load ? mem_out : 32'h0;
            err_q   <= 1'b0;
          end else begin
            cnt <= cnt_inc[TW-1:0];
            if (timeout_hit) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        RESP: cnt <= '0;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state. The bus is driven only while the
  // access is outstanding, and the strobes are suppressed for an illegal
  // command so the memory never sees both or a stray one.
  always_comb begin
    gnt       = '0;
    done      = '0;
    rdata     = '0;
    err       = 1'b0;
    mem_load  = 1'b0;
    mem_store = 1'b0;
    mem_type  = '0;
    mem_addr  = '0;
    mem_data  = '0;
    busy      = (state != IDLE);
    owner     = OWNER_NONE;
    case (state)
      ISSUE, WAIT: begin
        owner     = rr_last;
        mem_load  = cmd_legal & cmd_load;
        mem_store = cmd_legal & cmd_store;
        mem_type  = cmd_type;
        mem_addr  = cmd_addr;
        mem_data  = cmd_wdata;
        if (state == ISSUE) gnt = onehot3(rr_last);
      end
      RESP: begin
        owner = rr_last;
        done  = onehot3(rr_last);
        rdata = rdata_q;
        err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
